// File: rtl/instruction_loader_if.sv
// Load-port bundle between the UART byte source, the loader and the fetch stage.
// master = loader side, slave = environment side.
interface instruction_loader_if #(
  parameter int unsigned INSTRUCTION_BITS  = 32,
  parameter int unsigned MEM_SIZE_IN_WORDS = 20
);
  localparam int unsigned WCW = $clog2(MEM_SIZE_IN_WORDS + 1);

  logic                        i_start_load;
  logic [7:0]                  i_rx_data;
  logic                        i_rx_valid;
  logic                        i_full_mem;
  logic [INSTRUCTION_BITS-1:0] o_instruction;
  logic                        o_write_mem;
  logic                        o_busy;
  logic                        o_done;
  logic                        o_error;
  logic [WCW-1:0]              o_word_count;

  modport master (
    input  i_start_load,
    input  i_rx_data,
    input  i_rx_valid,
    input  i_full_mem,
    output o_instruction,
    output o_write_mem,
    output o_busy,
    output o_done,
    output o_error,
    output o_word_count
  );

  modport slave (
    output i_start_load,
    output i_rx_data,
    output i_rx_valid,
    output i_full_mem,
    input  o_instruction,
    input  o_write_mem,
    input  o_busy,
    input  o_done,
    input  o_error,
    input  o_word_count
  );
endinterface

// File: rtl/instruction_loader.sv
// Packs UART bytes MSB-first into instruction words and writes them
// into the fetch stage until the halt word, overflow or a stalled stream.
module instruction_loader #(
  parameter int unsigned INSTRUCTION_BITS  = 32,
  parameter int unsigned MEM_SIZE_IN_WORDS = 20,
  parameter logic [INSTRUCTION_BITS-1:0] HALT_WORD = '0,
  parameter int unsigned TIMEOUT_CYCLES    = 1000000
) (
  input logic i_clk,
  input logic i_reset,
  instruction_loader_if.master bus
);

  localparam int unsigned IB  = INSTRUCTION_BITS;
  localparam int unsigned BPW = IB / 8;
  localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned WCW = $clog2(MEM_SIZE_IN_WORDS + 1);
  localparam int unsigned TW  =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [BCW-1:0] LAST   = BCW'(BPW - 1);
  localparam logic [TW-1:0]  TMAX   = TW'(TIMEOUT_CYCLES);
  localparam bit             TMO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t          state_q, state_d;
  logic [IB-1:0]   shift_q, shift_d;
  logic [BCW-1:0]  bcnt_q, bcnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [IB-1:0]   instr_q, instr_d;
  logic            wr_q, wr_d;
  logic [WCW-1:0]  wc_q, wc_d;

  logic [IB+7:0]   cat;
  logic [IB-1:0]   word;

  assign cat  = {shift_q, bus.i_rx_data};
  assign word = cat[IB-1:0];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bcnt_q  <= '0;
      tmo_q   <= '0;
      instr_q <= '0;
      wr_q    <= 1'b0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      tmo_q   <= tmo_d;
      instr_q <= instr_d;
      wr_q    <= wr_d;
      wc_q    <= wc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    tmo_d   = tmo_q;
    instr_d = instr_q;
    wr_d    = 1'b0;
    wc_d    = wc_q;

    if (bus.i_start_load) begin
      state_d = S_RECV;
      shift_d = '0;
      bcnt_d  = '0;
      tmo_d   = '0;
      wc_d    = '0;
    end else begin
      unique case (state_q)
        S_RECV: begin
          if (bus.i_rx_valid) begin
            shift_d = word;
            tmo_d   = '0;
            if (bcnt_q == LAST) begin
              bcnt_d = '0;
              if (bus.i_full_mem) begin
                state_d = S_ERROR;
              end else begin
                instr_d = word;
                wr_d    = 1'b1;
                state_d = S_WRITE;
              end
            end else begin
              bcnt_d = bcnt_q + BCW'(1);
            end
          end else if (TMO_EN && bcnt_q != '0) begin
            // a partial word that stalls is dropped, never written
            if (tmo_q + TW'(1) == TMAX) begin
              state_d = S_ERROR;
              bcnt_d  = '0;
              tmo_d   = '0;
            end else begin
              tmo_d = tmo_q + TW'(1);
            end
          end
        end
        S_WRITE: begin
          wc_d = wc_q + WCW'(1);
          if (instr_q == HALT_WORD) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RECV;
            if (bus.i_rx_valid) begin
              shift_d = word;
              bcnt_d  = BCW'(1);
              tmo_d   = '0;
            end
          end
        end
        S_IDLE, S_DONE, S_ERROR: begin
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.o_instruction = instr_q;
  assign bus.o_write_mem   = wr_q;
  assign bus.o_busy        = (state_q == S_RECV) || (state_q == S_WRITE);
  assign bus.o_done        = (state_q == S_DONE);
  assign bus.o_error       = (state_q == S_ERROR);
  assign bus.o_word_count  = wc_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed and randomized checks of instruction_loader against a
// word-list reference model.
module tb_instruction_loader;

  logic i_clk   = 1'b0;
  logic i_reset = 1'b0;

  always #5 i_clk = ~i_clk;

  instruction_loader_if #(
    .INSTRUCTION_BITS(32),
    .MEM_SIZE_IN_WORDS(20)
  ) bus ();

  instruction_loader #(
    .INSTRUCTION_BITS(32),
    .MEM_SIZE_IN_WORDS(20),
    .HALT_WORD(32'h0000_0000),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .bus(bus)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] wq[$];
  int          long_pulse = 0;
  logic        wm_prev    = 1'b0;

  always @(negedge i_clk) begin
    if (bus.o_write_mem) begin
      wq.push_back(bus.o_instruction);
      if (wm_prev) long_pulse++;
    end
    wm_prev = bus.o_write_mem;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    tick();
    bus.i_rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap);
  endtask

  task automatic start();
    bus.i_start_load = 1'b1;
    tick();
    bus.i_start_load = 1'b0;
  endtask

  task automatic check_words(input string tag, input logic [31:0] want[$]);
    check({tag, " count"}, 32'(wq.size()), 32'(want.size()));
    for (int i = 0; i < want.size(); i++)
      if (i < wq.size()) check({tag, " word"}, wq[i], want[i]);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " instr"}, bus.o_instruction, 32'h0);
    check({tag, " wr"}, 32'(bus.o_write_mem), 32'h0);
    check({tag, " busy"}, 32'(bus.o_busy), 32'h0);
    check({tag, " done"}, 32'(bus.o_done), 32'h0);
    check({tag, " err"}, 32'(bus.o_error), 32'h0);
    check({tag, " wc"}, 32'(bus.o_word_count), 32'h0);
  endtask

  initial begin
    logic [31:0] want[$];
    logic [31:0] words[20];
    logic [31:0] w;
    int          k;
    int          n;
    int          gap;

    bus.i_start_load = 1'b0;
    bus.i_rx_data    = 8'h00;
    bus.i_rx_valid   = 1'b0;
    bus.i_full_mem   = 1'b0;

    #1;
    check_zero_outputs("por");
    repeat (2) tick();
    i_reset = 1'b1;
    tick();

    // bytes in IDLE are ignored
    send_word(32'h0102_0304, 0);
    repeat (2) tick();
    check("idle busy", 32'(bus.o_busy), 32'h0);
    check("idle writes", 32'(wq.size()), 32'h0);

    // two words with idle gaps, ending on halt
    start();
    wq.delete();
    send_word(32'hDEAD_BEEF, 3);
    send_word(32'h0000_0000, 3);
    want = '{32'hDEAD_BEEF, 32'h0000_0000};
    check_words("gap", want);
    check("gap wc", 32'(bus.o_word_count), 32'd2);
    check("gap done", 32'(bus.o_done), 32'h1);
    check("gap busy", 32'(bus.o_busy), 32'h0);

    // back-to-back, memory full after 20th write
    start();
    wq.delete();
    want.delete();
    for (int i = 0; i < 20; i++) begin
      w = $urandom();
      if (w == 32'h0) w = 32'h1;
      words[i] = w;
      want.push_back(w);
    end
    for (int i = 0; i < 21; i++) begin
      w = (i == 20) ? 32'h0 : words[i];
      for (int b = 3; b >= 0; b--) begin
        if (i == 20 && b == 3) bus.i_full_mem = 1'b1;
        send_byte(w[b*8 +: 8], 0);
      end
    end
    repeat (2) tick();
    check_words("full", want);
    check("full err", 32'(bus.o_error), 32'h1);
    check("full wc", 32'(bus.o_word_count), 32'd20);
    check("full busy", 32'(bus.o_busy), 32'h0);
    bus.i_full_mem = 1'b0;

    // stalled partial word
    start();
    check("restart err drop", 32'(bus.o_error), 32'h0);
    wq.delete();
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (bus.o_error) begin
        k = i;
        break;
      end
    end
    check("timeout cycles", 32'(k), 32'd50);
    check("timeout err", 32'(bus.o_error), 32'h1);
    check("timeout writes", 32'(wq.size()), 32'h0);

    // byte arriving in the WRITE cycle
    start();
    wq.delete();
    send_word(32'h1122_3344, 0);
    send_word(32'h5522_3344, 0);
    send_word(32'h0000_0000, 0);
    repeat (2) tick();
    want = '{32'h1122_3344, 32'h5522_3344, 32'h0};
    check_words("wrbyte", want);
    check("wrbyte wc", 32'(bus.o_word_count), 32'd3);
    check("wrbyte done", 32'(bus.o_done), 32'h1);

    // restart from DONE, then restart mid-word with a colliding byte
    start();
    check("done drop", 32'(bus.o_done), 32'h0);
    check("done busy", 32'(bus.o_busy), 32'h1);
    check("done wc", 32'(bus.o_word_count), 32'h0);
    wq.delete();
    send_byte(8'h12, 1);
    send_byte(8'h34, 1);
    bus.i_rx_data    = 8'h77;
    bus.i_rx_valid   = 1'b1;
    bus.i_start_load = 1'b1;
    tick();
    bus.i_rx_valid   = 1'b0;
    bus.i_start_load = 1'b0;
    send_word(32'hAABB_CCDD, 0);
    tick();
    want = '{32'hAABB_CCDD};
    check_words("restart", want);
    check("restart wc", 32'(bus.o_word_count), 32'd1);
    check("restart instr", bus.o_instruction, 32'hAABB_CCDD);

    // asynchronous reset mid-word
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    check("pre-rst busy", 32'(bus.o_busy), 32'h1);
    #2;
    i_reset = 1'b0;
    #1;
    check_zero_outputs("async rst");
    repeat (2) tick();
    i_reset = 1'b1;
    tick();
    check("post-rst busy", 32'(bus.o_busy), 32'h0);
    check("post-rst err", 32'(bus.o_error), 32'h0);

    // random sessions against the word-list model
    for (int s = 0; s < 4; s++) begin
      start();
      wq.delete();
      want.delete();
      n   = $urandom_range(1, 5);
      gap = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) begin
        w = $urandom();
        if (w == 32'h0) w = 32'hFFFF_FFFF;
        want.push_back(w);
      end
      want.push_back(32'h0);
      foreach (want[i]) send_word(want[i], gap);
      repeat (3) tick();
      check_words("rand", want);
      check("rand wc", 32'(bus.o_word_count), 32'(n + 1));
      check("rand done", 32'(bus.o_done), 32'h1);
    end

    check("pulse width", 32'(long_pulse), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Writer side of the fetch stage's instruction-memory load interface.
- Takes a byte stream from the debug UART receiver and packs each group of 4 bytes into a 32-bit instruction, MSB first.
- Drives the fetch stage's `i_instruction` / `i_write_mem` load port, one single-cycle write pulse per word.
- Terminates the program on the halt word, or flags an error on memory overflow or a stalled byte stream.

Parameters:
- INSTRUCTION_BITS, 32, width of an instruction word; must be a multiple of 8.
- MEM_SIZE_IN_WORDS, 20, instruction memory depth; sizes the word counter.
- HALT_WORD, 32'h00000000, end-of-program marker; it is written to memory, then loading ends.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles allowed mid-word before error; 0 disables the timeout.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_start_load  in  1  one-cycle pulse; (re)starts a load session.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid this cycle.
- i_full_mem  in  1  fetch-stage instruction memory full.
- o_instruction  out  INSTRUCTION_BITS  word presented to the fetch stage load port.
- o_write_mem  out  1  one-cycle write strobe to the fetch stage.
- o_busy  out  1  high in RECV or WRITE.
- o_done  out  1  high in DONE (halt word written).
- o_error  out  1  high in ERROR.
- o_word_count  out  $clog2(MEM_SIZE_IN_WORDS+1)  words written this session, including the halt word.

Behaviour:
- Reset (i_reset low, asynchronous, any state):
  - state = IDLE; all outputs 0; byte counter 0; timeout counter 0; shift register 0.
- States: IDLE, RECV, WRITE, DONE, ERROR. All outputs are registered.
- IDLE:
  - ignores i_rx_valid.
  - i_start_load -> RECV; clears word count, byte counter, timeout counter.
- RECV, each i_rx_valid:
  - shift register = {shift[INSTRUCTION_BITS-9:0], i_rx_data}; byte counter +1.
  - Byte counter wraps 3 -> 0 on the 4th byte (INSTRUCTION_BITS/8 bytes in general).
- RECV, on the 4th byte accepted at edge N:
  - if i_full_mem is high at edge N -> ERROR; no write.
  - else -> WRITE; o_instruction loads the assembled word at edge N; o_write_mem is high for the whole cycle after N (exactly one cycle).
- WRITE (lasts one cycle):
  - o_write_mem returns to 0 at the next edge; o_word_count increments at that edge.
  - if o_instruction == HALT_WORD -> DONE, else -> RECV.
  - An i_rx_valid during WRITE is accepted as byte 0 of the next word; no byte is lost.
  - o_instruction holds its value until the next word loads.
- Timeout:
  - counter runs in RECV only while byte counter != 0; clears on every i_rx_valid.
  - on reaching TIMEOUT_CYCLES -> ERROR; a partial word is never written.
- DONE / ERROR:
  - hold; ignore i_rx_valid.
  - i_start_load -> RECV with counters cleared; o_done and o_error drop at that edge.
- i_start_load in RECV or WRITE: restart the session; discard any partial word; word count = 0.
  - If in WRITE, the pending strobe still completes, but the word is not counted.
- i_start_load together with i_rx_valid: start wins; the byte is discarded.
- A byte counter != 0 never persists outside RECV/WRITE.

Test Plan:
- Reset low mid-word (2 bytes received) -> all outputs 0 immediately without a clock edge; state IDLE after release.
- Start, then bytes DE AD BE EF 00 00 00 00, 3 idle cycles between bytes:
  - o_write_mem pulses exactly twice, one cycle each.
  - o_instruction = 32'hDEADBEEF, then 32'h00000000.
  - o_word_count = 2; o_done = 1; o_busy = 0.
- Back-to-back bytes, one per cycle, 20 random non-zero words plus halt word, i_full_mem asserted after the 20th write:
  - 20 writes; 21st word -> o_error = 1, no 21st strobe; o_word_count = 20.
- TIMEOUT_CYCLES = 50, send 3 bytes then nothing:
  - o_error = 1 exactly 50 cycles after the 3rd byte; no write.
- Byte arriving in the WRITE cycle of word 11223344, followed by 3 more bytes 22 33 44:
  - next word 0x55223344 written (first byte 55 captured during WRITE).
- i_start_load after 2 bytes of a word, then 4 bytes AA BB CC DD:
  - single write of 32'hAABBCCDD; o_word_count = 1.
- i_start_load in DONE:
  - o_done drops; a new session loads from word count 0.
